// File: rtl/tile_instr_sequencer.sv
// Per-tile instruction store and issue engine feeding a CGRA tile.
// Streams a host-loaded program one word per cycle, with looping, stall and abort.
module tile_instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 64,
  parameter int LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               start,
  input  logic               stall,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  pc
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(7);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]  last_q, last_n;
  logic [LOOP_W-1:0]  loop_q, loop_n;
  logic [LOOP_W-1:0]  pass_q, pass_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n;
  logic               busy_n;
  logic               done_n;
  logic               issue;

  logic [ADDR_W-1:0]  cur_pc;
  logic [ADDR_W-1:0]  cur_last;
  logic [LOOP_W-1:0]  cur_pass;
  logic [LOOP_W-1:0]  cur_loop;

  // A start issues word 0 with the freshly presented bounds.
  assign cur_pc   = (state == RUN) ? pc     : '0;
  assign cur_pass = (state == RUN) ? pass_q : '0;
  assign cur_last = (state == RUN) ? last_q : last_addr;
  assign cur_loop = (state == RUN) ? loop_q : loop_count;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pass_n  = pass_q;
    last_n  = last_q;
    loop_n  = loop_q;
    instr_n = NOP;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    issue   = 1'b0;

    unique case (state)
      IDLE: begin
        pc_n   = '0;
        pass_n = '0;
        if (start) begin
          last_n = last_addr;
          loop_n = loop_count;
          issue  = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_n = IDLE;
          pc_n    = '0;
          pass_n  = '0;
        end else if (stall) begin
          busy_n = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        pc_n    = '0;
        pass_n  = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        pc_n    = '0;
        pass_n  = '0;
      end
    endcase

    if (issue) begin
      instr_n = mem[cur_pc];
      valid_n = 1'b1;
      busy_n  = 1'b1;
      if (cur_pc != cur_last) begin
        pc_n    = cur_pc + ADDR_W'(1);
        pass_n  = cur_pass;
        state_n = RUN;
      end else if (cur_pass != cur_loop) begin
        pc_n    = '0;
        pass_n  = cur_pass + LOOP_W'(1);
        state_n = RUN;
      end else begin
        pc_n    = '0;
        pass_n  = '0;
        state_n = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      pass_q      <= '0;
      last_q      <= '0;
      loop_q      <= '0;
      instruction <= NOP;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pass_q      <= pass_n;
      last_q      <= last_n;
      loop_q      <= loop_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Store is frozen while a program runs; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && state != RUN) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_tile_instr_sequencer.sv
// Bench for tile_instr_sequencer: directed scenarios then random traffic,
// checked against a queue-of-addresses model of a run.
module tb_tile_instr_sequencer;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 64;
  localparam int LOOP_W  = 8;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [INSTR_W-1:0] NOP = 64'h7;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               load_en = 1'b0;
  logic [ADDR_W-1:0]  load_addr = '0;
  logic [INSTR_W-1:0] load_data = '0;
  logic [ADDR_W-1:0]  last_addr = '0;
  logic [LOOP_W-1:0]  loop_count = '0;
  logic               start = 1'b0;
  logic               stall = 1'b0;
  logic               halt_req = 1'b0;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  pc;

  tile_instr_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .last_addr(last_addr), .loop_count(loop_count),
    .start(start), .stall(stall), .halt_req(halt_req),
    .instruction(instruction), .instr_valid(instr_valid),
    .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: program store plus the list of addresses still to issue.
  logic [INSTR_W-1:0] m_mem [DEPTH];
  int                 m_q[$];
  bit                 m_pend = 0;
  logic [INSTR_W-1:0] e_instr = NOP;
  logic               e_valid = 0;
  logic               e_busy = 0;
  logic               e_done = 0;
  logic [ADDR_W-1:0]  e_pc = 0;
  int                 n_valid = 0;
  int                 n_done = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got %h exp %h", tag, $time, got, exp);
    end
  endtask

  task automatic pop_word();
    int a;
    a = m_q.pop_front();
    e_instr = m_mem[a];
    e_valid = 1;
    e_busy  = 1;
    if (m_q.size() == 0) m_pend = 1;
  endtask

  task automatic model_edge();
    bit running;
    running = (m_q.size() != 0);
    e_instr = NOP;
    e_valid = 0;
    e_busy  = 0;
    e_done  = 0;
    if (!rst) begin
      m_q.delete();
      m_pend = 0;
    end else if (running) begin
      if (halt_req) m_q.delete();
      else if (stall) e_busy = 1;
      else pop_word();
    end else if (m_pend) begin
      m_pend = 0;
      e_done = 1;
    end else if (start) begin
      for (int p = 0; p <= int'(loop_count); p++)
        for (int a = 0; a <= int'(last_addr); a++)
          m_q.push_back(a);
      pop_word();
    end
    if (load_en && !running) m_mem[load_addr] = load_data;
    e_pc = (m_q.size() != 0) ? ADDR_W'(m_q[0]) : '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("instruction", instruction, e_instr);
    chk("instr_valid", 64'(instr_valid), 64'(e_valid));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("pc", 64'(pc), 64'(e_pc));
    if (instr_valid) n_valid++;
    if (done) n_done++;
  endtask

  task automatic quiet();
    load_en  = 0;
    start    = 0;
    stall    = 0;
    halt_req = 0;
    rst      = 1;
  endtask

  task automatic idle(int n);
    quiet();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(int a, logic [INSTR_W-1:0] d);
    quiet();
    load_en   = 1;
    load_addr = ADDR_W'(a);
    load_data = d;
    cyc();
    load_en = 0;
  endtask

  task automatic go(int last, int loops);
    quiet();
    start      = 1;
    last_addr  = ADDR_W'(last);
    loop_count = LOOP_W'(loops);
    cyc();
    start = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rst = 0;
    cyc();
    cyc();
    for (int i = 0; i < DEPTH; i++)
      load(i, {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(i << 3)});

    // Single pass of four words, done pulse, then filler.
    n_valid = 0;
    n_done  = 0;
    go(3, 0);
    idle(6);
    chk("t1_valid_count", 64'(n_valid), 64'd4);
    chk("t1_done_count", 64'(n_done), 64'd1);

    // Two words looped three times.
    n_valid = 0;
    go(1, 2);
    idle(8);
    chk("t2_valid_count", 64'(n_valid), 64'd6);

    // Two-cycle stall after A1.
    n_valid = 0;
    go(3, 0);
    cyc();
    stall = 1;
    cyc();
    cyc();
    stall = 0;
    idle(5);
    chk("t3_valid_count", 64'(n_valid), 64'd4);

    // Halt together with stall on the third cycle.
    n_done = 0;
    go(3, 0);
    cyc();
    stall    = 1;
    halt_req = 1;
    cyc();
    idle(4);
    chk("t4_no_done", 64'(n_done), 64'd0);

    // Load during RUN is dropped; start while busy is ignored.
    go(3, 0);
    load_en   = 1;
    load_addr = 2;
    load_data = 64'hDEAD_BEEF_0000_0000;
    start     = 1;
    cyc();
    idle(6);
    go(3, 0);
    idle(6);

    // Reset in the middle of a run.
    go(3, 1);
    cyc();
    rst = 0;
    cyc();
    idle(6);

    // One-word program, and a full-depth program that wraps.
    n_valid = 0;
    go(0, 0);
    idle(4);
    chk("t6_valid_count", 64'(n_valid), 64'd1);
    go(DEPTH - 1, 1);
    idle(2 * DEPTH + 4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      load_en  = ($urandom_range(0, 3) == 0);
      load_addr = ADDR_W'($urandom);
      load_data = {$urandom, $urandom};
      start    = ($urandom_range(0, 5) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      last_addr  = ADDR_W'($urandom);
      loop_count = LOOP_W'($urandom_range(0, 3));
      cyc();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
